// File: rtl/com_mmio_ctrl.sv
// Memory-mapped UART controller: RX/TX FIFOs, DATA/STATUS/CTRL registers,
// a TX start sequencer for the async transmitter and a level interrupt.
module com_mmio_ctrl #(
   parameter int RX_DEPTH_LOG = 4,
   parameter int TX_DEPTH_LOG = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  bus_addr,
   input  logic        bus_rd,
   input  logic        bus_wr,
   input  logic [7:0]  bus_wdata,
   output logic [31:0] bus_rdata,
   input  logic        rx_ready,
   input  logic [7:0]  rx_data,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   output logic        irq
);

   localparam int RXD = 1 << RX_DEPTH_LOG;
   localparam int TXD = 1 << TX_DEPTH_LOG;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT_BUSY,
      S_WAIT_DONE
   } tx_state_t;

   tx_state_t state, state_n;
   logic      wb_cnt, wb_cnt_n;

   logic [7:0]              rx_mem [RXD];
   logic [RX_DEPTH_LOG-1:0] rx_wptr, rx_rptr;
   logic [RX_DEPTH_LOG:0]   rx_count;
   logic [7:0]              tx_mem [TXD];
   logic [TX_DEPTH_LOG-1:0] tx_wptr, tx_rptr;
   logic [TX_DEPTH_LOG:0]   tx_count;

   logic rx_ready_q, rx_overrun, tx_overflow, rx_ie, tx_ie;
   logic rd_en, st_rd, rx_avail, rx_full, rx_push_req;
   logic rx_push, rx_pop, rx_drop;
   logic tx_push_req, tx_push, tx_pop, tx_drop;
   logic tx_full, tx_empty, tx_not_full, tx_idle;
   logic [7:0]  rx_cnt8;
   logic [31:0] rd_val;

   // A simultaneous write takes the bus; the read is dropped entirely.
   assign rd_en       = bus_rd & ~bus_wr;
   assign st_rd       = rd_en & (bus_addr == 2'd1);
   assign rx_avail    = |rx_count;
   assign rx_full     = rx_count[RX_DEPTH_LOG];
   assign rx_pop      = rd_en & (bus_addr == 2'd0) & rx_avail;
   assign rx_push_req = rx_ready & ~rx_ready_q;
   assign rx_push     = rx_push_req & (~rx_full | rx_pop);
   assign rx_drop     = rx_push_req & rx_full & ~rx_pop;

   assign tx_full     = tx_count[TX_DEPTH_LOG];
   assign tx_empty    = ~|tx_count;
   assign tx_not_full = ~tx_full;
   assign tx_push_req = bus_wr & (bus_addr == 2'd0);
   assign tx_push     = tx_push_req & (~tx_full | tx_pop);
   assign tx_drop     = tx_push_req & tx_full & ~tx_pop;
   assign tx_idle     = tx_empty & (state == S_IDLE) & ~tx_busy;
   assign rx_cnt8     = 8'(rx_count);

   always_comb begin
      rd_val = 32'h0;
      unique case (bus_addr)
         2'd0: if (rx_avail) rd_val = {24'h0, rx_mem[rx_rptr]};
         2'd1: rd_val = {16'h0, rx_cnt8, 3'b0, tx_overflow, tx_idle,
                         rx_overrun, tx_not_full, rx_avail};
         2'd2: rd_val = {30'h0, tx_ie, rx_ie};
         default: rd_val = 32'h0;
      endcase
   end

   // A start the transmitter never acknowledges times out after 2 cycles.
   always_comb begin
      state_n  = state;
      wb_cnt_n = wb_cnt;
      tx_pop   = 1'b0;
      unique case (state)
         S_IDLE: if (!tx_empty && !tx_busy) begin
            tx_pop   = 1'b1;
            wb_cnt_n = 1'b0;
            state_n  = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (tx_busy || wb_cnt) state_n = S_WAIT_DONE;
            else wb_cnt_n = 1'b1;
         end
         S_WAIT_DONE: if (!tx_busy) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wptr] <= rx_data;
      if (tx_push) tx_mem[tx_wptr] <= bus_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         wb_cnt      <= 1'b0;
         rx_wptr     <= '0;
         rx_rptr     <= '0;
         rx_count    <= '0;
         tx_wptr     <= '0;
         tx_rptr     <= '0;
         tx_count    <= '0;
         rx_ready_q  <= 1'b0;
         rx_overrun  <= 1'b0;
         tx_overflow <= 1'b0;
         rx_ie       <= 1'b0;
         tx_ie       <= 1'b0;
         bus_rdata   <= 32'h0;
         tx_start    <= 1'b0;
         tx_data     <= 8'h0;
         irq         <= 1'b0;
      end else begin
         state      <= state_n;
         wb_cnt     <= wb_cnt_n;
         rx_ready_q <= rx_ready;
         tx_start   <= tx_pop;
         if (tx_pop) tx_data <= tx_mem[tx_rptr];
         if (rx_push) rx_wptr <= rx_wptr + RX_DEPTH_LOG'(1);
         if (rx_pop) rx_rptr <= rx_rptr + RX_DEPTH_LOG'(1);
         if (rx_push && !rx_pop)
            rx_count <= rx_count + (RX_DEPTH_LOG+1)'(1);
         else if (rx_pop && !rx_push)
            rx_count <= rx_count - (RX_DEPTH_LOG+1)'(1);
         if (tx_push) tx_wptr <= tx_wptr + TX_DEPTH_LOG'(1);
         if (tx_pop) tx_rptr <= tx_rptr + TX_DEPTH_LOG'(1);
         if (tx_push && !tx_pop)
            tx_count <= tx_count + (TX_DEPTH_LOG+1)'(1);
         else if (tx_pop && !tx_push)
            tx_count <= tx_count - (TX_DEPTH_LOG+1)'(1);
         // Same-edge events win over the STATUS read clear.
         rx_overrun  <= rx_drop | (rx_overrun & ~st_rd);
         tx_overflow <= tx_drop | (tx_overflow & ~st_rd);
         if (bus_wr && bus_addr == 2'd2) {tx_ie, rx_ie} <= bus_wdata[1:0];
         if (rd_en) bus_rdata <= rd_val;
         irq <= (rx_ie & rx_avail) | (tx_ie & tx_idle);
      end
   end

endmodule

// File: tb/tb_com_mmio_ctrl.sv
// Directed bench for com_mmio_ctrl with a transmitter model and
// read/transmit scoreboards.
module tb_com_mmio_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  bus_addr = '0;
   logic        bus_rd = 1'b0;
   logic        bus_wr = 1'b0;
   logic [7:0]  bus_wdata = '0;
   logic [31:0] bus_rdata;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        tx_start;
   logic [7:0]  tx_data;
   logic        tx_busy;
   logic        irq;

   int total = 0;
   int bad = 0;
   int tx_starts = 0;
   int mcnt = 0;
   logic force_busy = 1'b0;
   logic start_prev = 1'b0;
   logic busy_prev = 1'b0;
   logic [31:0] rdq[$];
   logic [31:0] txq[$];

   com_mmio_ctrl #(.RX_DEPTH_LOG(4), .TX_DEPTH_LOG(4)) dut (
      .clk(clk), .rst(rst), .bus_addr(bus_addr), .bus_rd(bus_rd),
      .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
      .rx_ready(rx_ready), .rx_data(rx_data), .tx_start(tx_start),
      .tx_data(tx_data), .tx_busy(tx_busy), .irq(irq)
   );

   always #5 clk = ~clk;

   // Transmitter model: busy for 5 cycles after each start, unaffected by rst.
   always @(posedge clk) begin
      if (tx_start) mcnt <= 5;
      else if (mcnt != 0) mcnt <= mcnt - 1;
   end
   assign tx_busy = (mcnt != 0) | force_busy;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         if (tx_start) begin
            logic [31:0] e;
            e = (txq.size() != 0) ? txq.pop_front() : 32'h100;
            chk("tx_data", {24'h0, tx_data}, e);
            chk("tx_start_gap", {29'h0, start_prev, busy_prev, tx_busy}, 0);
            tx_starts++;
         end
         start_prev = tx_start;
         busy_prev  = tx_busy;
      end else begin
         start_prev = 1'b0;
         busy_prev  = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input logic [31:0] exp,
                     input string tag);
      rdq.push_back(exp);
      bus_addr = a;
      bus_rd = 1'b1;
      tick();
      bus_rd = 1'b0;
      chk(tag, bus_rdata, rdq.pop_front());
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      bus_addr = a;
      bus_wdata = d;
      bus_wr = 1'b1;
      tick();
      bus_wr = 1'b0;
   endtask

   task automatic rx(input logic [7:0] d);
      rx_data = d;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      tick();
   endtask

   task automatic wait_starts(input int n, input int budget);
      int k = 0;
      while (tx_starts < n && k < budget) begin
         tick();
         k++;
      end
      chk("tx_starts", tx_starts, n);
   endtask

   task automatic wait_quiet(input int budget);
      int k = 0;
      while (tx_busy && k < budget) begin
         tick();
         k++;
      end
      chk("busy_fall", {31'h0, tx_busy}, 0);
      tick();
   endtask

   initial begin
      int base;
      tick();
      tick();
      chk("rst_rdata", bus_rdata, 0);
      chk("rst_txs", {31'h0, tx_start}, 0);
      chk("rst_txd", {24'h0, tx_data}, 0);
      chk("rst_irq", {31'h0, irq}, 0);
      rst = 1'b1;
      tick();
      rd(2'd1, 32'h0000_000A, "status_reset");
      chk("irq_reset", {31'h0, irq}, 0);
      rd(2'd3, 32'h0, "addr3");

      rx(8'hF3);
      rx(8'h41);
      rd(2'd1, 32'h0000_020B, "status_rx2");
      rd(2'd0, 32'hF3, "data_f3");
      rd(2'd0, 32'h41, "data_41");
      rd(2'd0, 32'h0, "data_empty");
      rd(2'd1, 32'h0000_000A, "status_empty");

      rx_data = 8'h77;
      rx_ready = 1'b1;
      repeat (4) tick();
      rx_ready = 1'b0;
      tick();
      rd(2'd1, 32'h0000_010B, "status_held");
      rd(2'd0, 32'h77, "data_held");

      for (int i = 0; i < 17; i++) rx(8'(i));
      rd(2'd1, 32'h0000_100F, "status_overrun");
      for (int i = 0; i < 16; i++) rd(2'd0, 32'(i), "data_fill");
      rd(2'd1, 32'h0000_000A, "status_ovr_clr");

      for (int i = 0; i < 16; i++) rx(8'(8'h20 + i));
      rx_data = 8'h30;
      rx_ready = 1'b1;
      rdq.push_back(32'h20);
      bus_addr = 2'd0;
      bus_rd = 1'b1;
      tick();
      bus_rd = 1'b0;
      rx_ready = 1'b0;
      chk("data_coinc", bus_rdata, rdq.pop_front());
      tick();
      rd(2'd1, 32'h0000_100B, "status_no_ovr");
      for (int i = 1; i < 17; i++) rd(2'd0, 32'(8'h20 + i), "data_coinc_q");
      rd(2'd1, 32'h0000_000A, "status_empty2");

      wr(2'd2, 8'h01);
      rd(2'd2, 32'h1, "ctrl_rd");
      rx_data = 8'h55;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      chk("irq_lag", {31'h0, irq}, 0);
      tick();
      chk("irq_rx", {31'h0, irq}, 1);
      rd(2'd0, 32'h55, "data_55");
      tick();
      chk("irq_drain", {31'h0, irq}, 0);
      rx(8'h66);
      tick();
      chk("irq_rx2", {31'h0, irq}, 1);
      wr(2'd2, 8'h00);
      tick();
      chk("irq_dis", {31'h0, irq}, 0);
      rd(2'd0, 32'h66, "data_66");

      txq.push_back(32'h48);
      wr(2'd0, 8'h48);
      txq.push_back(32'h49);
      wr(2'd0, 8'h49);
      wait_starts(2, 200);
      wait_quiet(50);
      rd(2'd1, 32'h0000_000A, "status_tx_done");
      wr(2'd2, 8'h02);
      tick();
      chk("irq_tx", {31'h0, irq}, 1);

      bus_addr = 2'd2;
      bus_wdata = 8'h01;
      bus_rd = 1'b1;
      bus_wr = 1'b1;
      tick();
      bus_rd = 1'b0;
      bus_wr = 1'b0;
      chk("rdwr_hold", bus_rdata, 32'h0000_000A);
      rd(2'd2, 32'h1, "rdwr_ctrl");
      wr(2'd2, 8'h00);
      wr(2'd3, 8'h03);
      rd(2'd2, 32'h0, "ctrl_wr3");

      force_busy = 1'b1;
      for (int i = 0; i < 17; i++) begin
         if (i < 16) txq.push_back(32'(8'h80 + i));
         wr(2'd0, 8'(8'h80 + i));
      end
      rd(2'd1, 32'h0000_0010, "status_tx_ovf");
      base = tx_starts;
      force_busy = 1'b0;
      wait_starts(base + 16, 1000);
      wait_quiet(50);
      rd(2'd1, 32'h0000_000A, "status_drained");
      chk("txq_empty", txq.size(), 0);

      base = tx_starts;
      for (int i = 0; i < 6; i++) begin
         txq.push_back(32'(8'hC0 + i));
         wr(2'd0, 8'(8'hC0 + i));
      end
      wait_starts(base + 2, 200);
      rst = 1'b0;
      #1;
      txq.delete();
      chk("mid_rst_txs", {31'h0, tx_start}, 0);
      chk("mid_rst_rdata", bus_rdata, 0);
      chk("mid_rst_irq", {31'h0, irq}, 0);
      tick();
      rst = 1'b1;
      wait_quiet(50);
      rd(2'd1, 32'h0000_000A, "status_post_rst");
      base = tx_starts;
      repeat (20) tick();
      chk("no_start_post_rst", tx_starts, base);
      txq.push_back(32'h5A);
      wr(2'd0, 8'h5A);
      wait_starts(base + 1, 100);
      wait_quiet(50);
      chk("txq_final", txq.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
